// File: rtl/instr_register_calc_if.sv
// Bus bundle for instr_register_calc: write request, read pointer and registered read port.
// master drives requests; slave is the register file.
interface instr_register_calc_if #(
    parameter int OP_W  = 32,
    parameter int DEPTH = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  load_en;
    logic [3:0]            opcode;
    logic [OP_W-1:0]       operand_a;
    logic [OP_W-1:0]       operand_b;
    logic [ADDR_W-1:0]     write_pointer;
    logic [ADDR_W-1:0]     read_pointer;
    logic                  busy;
    logic                  wr_done;
    logic                  rd_valid;
    logic [3:0]            rd_opcode;
    logic [OP_W-1:0]       rd_op_a;
    logic [OP_W-1:0]       rd_op_b;
    logic [2*OP_W-1:0]     rd_result;

    modport master (
        output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  busy, wr_done, rd_valid, rd_opcode, rd_op_a, rd_op_b, rd_result
    );

    modport slave (
        input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output busy, wr_done, rd_valid, rd_opcode, rd_op_a, rd_op_b, rd_result
    );
endinterface

// File: rtl/instr_register_calc.sv
// Instruction register with write-time result computation: single-cycle ALU ops and
// a restoring iterative divider for DIV/MOD, plus a one-cycle-latency registered read port.
module instr_register_calc #(
    parameter int OP_W  = 32,
    parameter int DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_register_calc_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int RES_W  = 2 * OP_W;
    localparam int CNT_W  = (OP_W > 2) ? $clog2(OP_W) : 1;

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DIV_FIN = 2'd2
    } state_e;

    function automatic logic [OP_W-1:0] abs_val(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? ((~v) + OP_W'(1)) : v;
    endfunction

    function automatic logic [RES_W-1:0] sext(input logic [OP_W-1:0] v);
        return {{OP_W{v[OP_W-1]}}, v};
    endfunction

    function automatic logic [RES_W-1:0] negate(input logic [RES_W-1:0] v);
        return (~v) + RES_W'(1);
    endfunction

    state_e              state_q;
    logic                busy_q;
    logic                wr_done_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [3:0]          stg_opc_q;
    logic [OP_W-1:0]     stg_a_q;
    logic [OP_W-1:0]     stg_b_q;
    logic [ADDR_W-1:0]   stg_ptr_q;
    logic                stg_a_neg_q;
    logic                stg_b_neg_q;
    logic [OP_W-1:0]     div_b_q;
    logic [OP_W-1:0]     quo_q;
    logic [OP_W-1:0]     rem_q;

    logic [3:0]          mem_opc_q [DEPTH];
    logic [OP_W-1:0]     mem_a_q   [DEPTH];
    logic [OP_W-1:0]     mem_b_q   [DEPTH];
    logic [RES_W-1:0]    mem_res_q [DEPTH];
    logic [DEPTH-1:0]    valid_q;

    logic                rd_valid_q;
    logic [3:0]          rd_opc_q;
    logic [OP_W-1:0]     rd_a_q;
    logic [OP_W-1:0]     rd_b_q;
    logic [RES_W-1:0]    rd_res_q;

    logic                is_div_s;
    logic                start_div_s;
    logic                fast_wr_s;
    logic                fin_wr_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_ptr_s;
    logic [3:0]          wr_opc_s;
    logic [OP_W-1:0]     wr_a_s;
    logic [OP_W-1:0]     wr_b_s;
    logic [RES_W-1:0]    wr_res_s;
    logic [RES_W-1:0]    fast_res_s;
    logic [RES_W-1:0]    fin_res_s;
    logic [OP_W:0]       rem_shift_s;
    logic [OP_W:0]       diff_s;
    logic [OP_W-1:0]     rem_nxt_s;
    logic                q_bit_s;

    // Single-cycle result; DIV/MOD only reach this path with a zero divisor, giving 0.
    always_comb begin
        fast_res_s = {RES_W{1'b0}};
        case (bus.opcode)
            OPC_ZERO:  fast_res_s = {RES_W{1'b0}};
            OPC_PASSA: fast_res_s = sext(bus.operand_a);
            OPC_PASSB: fast_res_s = sext(bus.operand_b);
            OPC_ADD:   fast_res_s = sext(bus.operand_a) + sext(bus.operand_b);
            OPC_SUB:   fast_res_s = sext(bus.operand_a) - sext(bus.operand_b);
            OPC_MULT:  fast_res_s = sext(bus.operand_a) * sext(bus.operand_b);
            default:   fast_res_s = {RES_W{1'b0}};
        endcase
    end

    // One restoring-division step on magnitudes, plus sign correction of the final result.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[OP_W-1]};
        diff_s      = rem_shift_s - {1'b0, div_b_q};
        if (diff_s[OP_W]) begin
            rem_nxt_s = rem_shift_s[OP_W-1:0];
            q_bit_s   = 1'b0;
        end else begin
            rem_nxt_s = diff_s[OP_W-1:0];
            q_bit_s   = 1'b1;
        end
        if (stg_opc_q == OPC_DIV) begin
            fin_res_s = (stg_a_neg_q ^ stg_b_neg_q) ? negate({{OP_W{1'b0}}, quo_q})
                                                    : {{OP_W{1'b0}}, quo_q};
        end else begin
            fin_res_s = stg_a_neg_q ? negate({{OP_W{1'b0}}, rem_q}) : {{OP_W{1'b0}}, rem_q};
        end
    end

    // Write-port arbitration between an immediate IDLE write and the divider completion.
    always_comb begin
        is_div_s    = (bus.opcode == OPC_DIV) || (bus.opcode == OPC_MOD);
        start_div_s = (state_q == ST_IDLE) && bus.load_en && is_div_s &&
                      (bus.operand_b != {OP_W{1'b0}});
        fast_wr_s   = (state_q == ST_IDLE) && bus.load_en && !start_div_s;
        fin_wr_s    = (state_q == ST_DIV_FIN);
        wr_en_s     = fast_wr_s || fin_wr_s;
        if (fin_wr_s) begin
            wr_ptr_s = stg_ptr_q;
            wr_opc_s = stg_opc_q;
            wr_a_s   = stg_a_q;
            wr_b_s   = stg_b_q;
            wr_res_s = fin_res_s;
        end else begin
            wr_ptr_s = bus.write_pointer;
            wr_opc_s = bus.opcode;
            wr_a_s   = bus.operand_a;
            wr_b_s   = bus.operand_b;
            wr_res_s = fast_res_s;
        end
    end

    // Control FSM, divider datapath and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            wr_done_q   <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            stg_opc_q   <= 4'd0;
            stg_a_q     <= {OP_W{1'b0}};
            stg_b_q     <= {OP_W{1'b0}};
            stg_ptr_q   <= {ADDR_W{1'b0}};
            stg_a_neg_q <= 1'b0;
            stg_b_neg_q <= 1'b0;
            div_b_q     <= {OP_W{1'b0}};
            quo_q       <= {OP_W{1'b0}};
            rem_q       <= {OP_W{1'b0}};
        end else begin
            wr_done_q <= wr_en_s;
            case (state_q)
                ST_IDLE: begin
                    if (start_div_s) begin
                        stg_opc_q   <= bus.opcode;
                        stg_a_q     <= bus.operand_a;
                        stg_b_q     <= bus.operand_b;
                        stg_ptr_q   <= bus.write_pointer;
                        stg_a_neg_q <= bus.operand_a[OP_W-1];
                        stg_b_neg_q <= bus.operand_b[OP_W-1];
                        div_b_q     <= abs_val(bus.operand_b);
                        quo_q       <= abs_val(bus.operand_a);
                        rem_q       <= {OP_W{1'b0}};
                        cnt_q       <= {CNT_W{1'b0}};
                        busy_q      <= 1'b1;
                        state_q     <= ST_DIV_RUN;
                    end else begin
                        busy_q      <= 1'b0;
                    end
                end
                ST_DIV_RUN: begin
                    quo_q <= {quo_q[OP_W-2:0], q_bit_s};
                    rem_q <= rem_nxt_s;
                    if (cnt_q == CNT_W'(OP_W - 1)) begin
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= ST_DIV_FIN;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DIV_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Entry storage and registered read port; a same-edge read sees the pre-write contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_opc_q[i] <= 4'd0;
                mem_a_q[i]   <= {OP_W{1'b0}};
                mem_b_q[i]   <= {OP_W{1'b0}};
                mem_res_q[i] <= {RES_W{1'b0}};
            end
            valid_q    <= {DEPTH{1'b0}};
            rd_valid_q <= 1'b0;
            rd_opc_q   <= 4'd0;
            rd_a_q     <= {OP_W{1'b0}};
            rd_b_q     <= {OP_W{1'b0}};
            rd_res_q   <= {RES_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_opc_q[wr_ptr_s] <= wr_opc_s;
                mem_a_q[wr_ptr_s]   <= wr_a_s;
                mem_b_q[wr_ptr_s]   <= wr_b_s;
                mem_res_q[wr_ptr_s] <= wr_res_s;
                valid_q[wr_ptr_s]   <= 1'b1;
            end
            rd_valid_q <= valid_q[bus.read_pointer];
            rd_opc_q   <= mem_opc_q[bus.read_pointer];
            rd_a_q     <= mem_a_q[bus.read_pointer];
            rd_b_q     <= mem_b_q[bus.read_pointer];
            rd_res_q   <= mem_res_q[bus.read_pointer];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_opcode = rd_opc_q;
    assign bus.rd_op_a   = rd_a_q;
    assign bus.rd_op_b   = rd_b_q;
    assign bus.rd_result = rd_res_q;
endmodule
